// File: rtl/cpu_clock_ctrl.sv
// Processor clock generator: programmable-divider cpu_clock with run, halt, debounced
// single-step and counted-burst modes, plus a rise-enable pulse and a retired-cycle counter.
module cpu_clock_ctrl #(
  parameter int CNT_W       = 24,
  parameter int DIV_DEFAULT = 9000000,
  parameter int DBNC_CYCLES = 1000000,
  parameter int BURST_W     = 16
) (
  input  logic               clock,
  input  logic               reset_i,
  input  logic [1:0]         mode,
  input  logic               step_btn,
  input  logic               div_load,
  input  logic [CNT_W-1:0]   div_value,
  input  logic [BURST_W-1:0] burst_len,
  output logic               cpu_clock,
  output logic               cpu_rise_en,
  output logic [31:0]        cycle_count,
  output logic               running
);

  localparam logic [1:0] MODE_RUN   = 2'b00;
  localparam logic [1:0] MODE_STEP  = 2'b01;
  localparam logic [1:0] MODE_BURST = 2'b11;
  localparam int DBNC_W = (DBNC_CYCLES > 1) ? $clog2(DBNC_CYCLES) : 1;
  localparam logic [DBNC_W-1:0] DBNC_LAST = DBNC_W'(DBNC_CYCLES - 1);
  localparam logic [CNT_W-1:0]  HP_RESET  = CNT_W'(DIV_DEFAULT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [CNT_W-1:0]   cnt_reg, cnt_next, hp_reg;
  logic               cpu_clock_reg, rise_reg;
  logic [31:0]        count_reg;
  logic [BURST_W-1:0] rem_reg, rem_next, rem_avail;
  logic [1:0]         mode_prev_reg;

  logic              sync1_reg, sync2_reg;
  logic              dbnc_level_reg, step_trig_reg;
  logic [DBNC_W-1:0] dbnc_cnt_reg;

  logic phase_end, burst_entry, run_req, burst_req, start;

  assign phase_end   = (state_reg != IDLE) && (cnt_reg == hp_reg - CNT_W'(1));
  // A fresh entry into burst mode sees burst_len immediately, so the first
  // period can start on the very cycle the mode is first observed.
  assign burst_entry = (mode == MODE_BURST) && (mode_prev_reg != MODE_BURST) && (state_reg == IDLE);
  assign rem_avail   = burst_entry ? burst_len : rem_reg;
  assign run_req     = (mode == MODE_RUN);
  assign burst_req   = (mode == MODE_BURST) && (rem_avail != '0);

  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    case (state_reg)
      IDLE: start = run_req || burst_req || ((mode == MODE_STEP) && step_trig_reg);
      HI: begin
        if (phase_end) state_next = LO;
      end
      LO: begin
        if (phase_end) begin
          if (run_req || burst_req) start = 1'b1;
          else                      state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (start) state_next = HI;

    rem_next = rem_avail;
    if (start && (mode == MODE_BURST)) rem_next = rem_avail - BURST_W'(1);

    cnt_next = cnt_reg + CNT_W'(1);
    if (div_load || (state_reg == IDLE) || phase_end) cnt_next = '0;
  end

  always_ff @(posedge clock) begin
    if (!reset_i) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      hp_reg        <= HP_RESET;
      cpu_clock_reg <= 1'b0;
      rise_reg      <= 1'b0;
      count_reg     <= '0;
      rem_reg       <= '0;
      mode_prev_reg <= MODE_RUN;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (div_load) hp_reg <= (div_value == '0) ? CNT_W'(1) : div_value;
      cpu_clock_reg <= (state_next == HI);
      rise_reg      <= start;
      count_reg     <= count_reg + 32'(start);
      rem_reg       <= rem_next;
      mode_prev_reg <= mode;
    end
  end

  // Button path: two-flop synchroniser, then a level must differ for
  // DBNC_CYCLES consecutive cycles before it is accepted.
  always_ff @(posedge clock) begin
    if (!reset_i) begin
      sync1_reg      <= 1'b0;
      sync2_reg      <= 1'b0;
      dbnc_level_reg <= 1'b0;
      dbnc_cnt_reg   <= '0;
      step_trig_reg  <= 1'b0;
    end else begin
      sync1_reg     <= step_btn;
      sync2_reg     <= sync1_reg;
      step_trig_reg <= 1'b0;
      if (sync2_reg != dbnc_level_reg) begin
        if (dbnc_cnt_reg == DBNC_LAST) begin
          dbnc_level_reg <= sync2_reg;
          dbnc_cnt_reg   <= '0;
          step_trig_reg  <= sync2_reg;
        end else begin
          dbnc_cnt_reg <= dbnc_cnt_reg + DBNC_W'(1);
        end
      end else begin
        dbnc_cnt_reg <= '0;
      end
    end
  end

  assign cpu_clock   = cpu_clock_reg;
  assign cpu_rise_en = rise_reg;
  assign cycle_count = count_reg;
  assign running     = (state_reg != IDLE);

endmodule
